// File: rtl/vdp_pkg.sv
// Shared types and default sizing for the multi-cycle dot-product engine.
// Optional saturating arithmetic is enabled with `define VDP_SATURATE_EN.
package vdp_pkg;

    localparam int unsigned VDP_VECTOR_SIZE = 4;
    localparam int unsigned VDP_DATA_WIDTH  = 31;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } vdp_state_e;

endpackage

// File: rtl/vdp_mac_unit.sv
// Multiply-accumulate unit: one product per enabled cycle into a clearable accumulator.
// Wraps modulo 2^DATA_WIDTH by default; clamps to all-ones when VDP_SATURATE_EN is defined.
module vdp_mac_unit
    import vdp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = VDP_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] acc
);

    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0] acc_next;

`ifdef VDP_SATURATE_EN
    localparam int unsigned PW = 2 * DATA_WIDTH;

    logic [PW-1:0]       prod_full;
    logic [DATA_WIDTH:0] sum_full;

    // Any bit above the result width means the product or sum overflowed.
    always_comb begin
        prod_full = PW'(a) * PW'(b);
        prod      = (|prod_full[PW-1:DATA_WIDTH]) ? '1 : prod_full[DATA_WIDTH-1:0];
        sum_full  = {1'b0, acc_q} + {1'b0, prod};
        acc_next  = sum_full[DATA_WIDTH] ? '1 : sum_full[DATA_WIDTH-1:0];
    end
`else
    always_comb begin
        prod     = a * b;
        acc_next = acc_q + prod;
    end
`endif

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/vector_dot_product_mc.sv
// Free-running unsigned dot-product engine: LOAD snapshot, VECTOR_SIZE MAC cycles, DONE strobe.
// Define VDP_SATURATE_EN to clamp products and sums instead of wrapping.
module vector_dot_product_mc
    import vdp_pkg::*;
#(
    parameter int unsigned VECTOR_SIZE = VDP_VECTOR_SIZE,
    parameter int unsigned DATA_WIDTH  = VDP_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] vec1 [VECTOR_SIZE],
    input  logic [DATA_WIDTH-1:0] vec2 [VECTOR_SIZE],
    output logic [DATA_WIDTH-1:0] result,
    output logic                  valid
);

    localparam int unsigned IDX_W = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VECTOR_SIZE - 1);

    vdp_state_e            state_q, state_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic [DATA_WIDTH-1:0] snap1_q [VECTOR_SIZE];
    logic [DATA_WIDTH-1:0] snap1_d [VECTOR_SIZE];
    logic [DATA_WIDTH-1:0] snap2_q [VECTOR_SIZE];
    logic [DATA_WIDTH-1:0] snap2_d [VECTOR_SIZE];
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  valid_q, valid_d;

    logic                  mac_clr_c;
    logic                  mac_en_c;
    logic [DATA_WIDTH-1:0] mac_acc;

    vdp_mac_unit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst_n (reset),
        .clr   (mac_clr_c),
        .en    (mac_en_c),
        .a     (snap1_q[index_q]),
        .b     (snap2_q[index_q]),
        .acc   (mac_acc)
    );

    // Next-state, snapshot capture, index stepping and result publication.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        snap1_d   = snap1_q;
        snap2_d   = snap2_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        mac_clr_c = 1'b0;
        mac_en_c  = 1'b0;

        case (state_q)
            LOAD: begin
                snap1_d   = vec1;
                snap2_d   = vec2;
                index_d   = '0;
                mac_clr_c = 1'b1;
                state_d   = MAC;
            end
            MAC: begin
                mac_en_c = 1'b1;
                if (index_q == LAST_IDX) begin
                    index_d = '0;
                    state_d = DONE;
                end else begin
                    index_d = index_q + IDX_W'(1);
                end
            end
            DONE: begin
                result_d = mac_acc;
                valid_d  = 1'b1;
                state_d  = LOAD;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= LOAD;
            index_q  <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            for (int i = 0; i < int'(VECTOR_SIZE); i++) begin
                snap1_q[i] <= '0;
                snap2_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            snap1_q  <= snap1_d;
            snap2_q  <= snap2_d;
        end
    end

    assign result = result_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_vector_dot_product_mc.sv
// Directed bench for vector_dot_product_mc with a queue scoreboard of expected results.
module tb_vector_dot_product_mc;

    localparam int unsigned VS = 4;
    localparam int unsigned DW = 31;

    typedef logic [DW-1:0] vec_t [VS];

    logic          clk;
    logic          reset;
    logic [DW-1:0] vec1 [VS];
    logic [DW-1:0] vec2 [VS];
    logic [DW-1:0] result;
    logic          valid;

    logic [DW-1:0] sb [$];
    logic [DW-1:0] last_result;
    int            total;
    int            bad;

    vector_dot_product_mc #(
        .VECTOR_SIZE (VS),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .vec1   (vec1),
        .vec2   (vec2),
        .result (result),
        .valid  (valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DW-1:0] model(input vec_t a, input vec_t b);
        longint unsigned mask;
        longint unsigned acc;
        longint unsigned p;
        mask = (64'd1 << DW) - 64'd1;
        acc  = 0;
        for (int i = 0; i < int'(VS); i++) begin
            p = longint'(a[i]) * longint'(b[i]);
`ifdef VDP_SATURATE_EN
            if (p > mask) p = mask;
            acc = acc + p;
            if (acc > mask) acc = mask;
`else
            acc = (acc + (p & mask)) & mask;
`endif
        end
        return DW'(acc);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Drives one pass from a LOAD edge; optionally rewrites vec1 after chg_step edges.
    task automatic do_pass(input vec_t v1, input vec_t v2, input string tag,
                           input int chg_step, input vec_t chg_v1);
        logic [DW-1:0] exp;
        vec1 = v1;
        vec2 = v2;
        sb.push_back(model(v1, v2));
        for (int s = 1; s <= 5; s++) begin
            step();
            if (s == chg_step) vec1 = chg_v1;
            check({tag, "_valid_lo"}, 32'(valid), 32'd0);
            if (s == 3) check({tag, "_hold"}, 32'(result), 32'(last_result));
        end
        step();
        check({tag, "_valid_hi"}, 32'(valid), 32'd1);
        exp = sb.pop_front();
        check({tag, "_result"}, 32'(result), 32'(exp));
        last_result = exp;
    endtask

    initial begin
        vec_t z, a, b, ones, tens, ovf1, ovf2, mx, r1, r2;
        total = 0;
        bad   = 0;
        last_result = '0;
        z    = '{0, 0, 0, 0};
        a    = '{1, 2, 3, 4};
        b    = '{5, 6, 7, 8};
        ones = '{1, 1, 1, 1};
        tens = '{10, 10, 10, 10};
        ovf1 = '{31'h4000_0000, 0, 0, 0};
        ovf2 = '{2, 0, 0, 0};
        mx   = '{31'h7fff_ffff, 0, 0, 0};
        for (int i = 0; i < int'(VS); i++) begin
            r1[i] = DW'($urandom);
            r2[i] = DW'($urandom_range(0, 65535));
        end

        reset = 1'b0;
        vec1  = z;
        vec2  = z;
        repeat (3) step();
        check("rst_result", 32'(result), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);

        reset = 1'b1;
        do_pass(z, z, "zero0", 0, z);
        do_pass(z, z, "zero1", 0, z);
        do_pass(a, b, "basic70", 0, z);
        do_pass(ovf1, ovf2, "overflow", 0, z);
        do_pass(mx, mx, "maxop", 0, z);
        do_pass(a, ones, "midchg", 2, tens);
        do_pass(tens, ones, "after_chg", 0, z);
        do_pass(r1, r2, "random", 0, z);
        do_pass(a, b, "pre_rst", 0, z);

        // Abandon a pass during its third MAC cycle.
        vec1 = a;
        vec2 = b;
        repeat (3) step();
        #2 reset = 1'b0;
        #1;
        check("midrst_result", 32'(result), 32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        repeat (2) step();
        reset = 1'b1;
        last_result = '0;
        do_pass(a, b, "post_rst", 0, z);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
